// File: rtl/bnn_serial_loader.sv
// bnn_serial_loader: shifts a serial binary image and a serial MSB-first weight kernel into parallel arrays for layer one
module bnn_serial_loader #(
  parameter int IMG_DIM = 28,
  parameter int K_DIM = 3,
  parameter int W_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en_wr,
  input  logic bit_valid,
  input  logic d_in_p,
  input  logic d_in_w,
  output logic [IMG_DIM-1:0][IMG_DIM-1:0] pixels,
  output logic [K_DIM-1:0][K_DIM-1:0][W_BITS-1:0] weights,
  output logic load_done,
  output logic [9:0] pix_count,
  output logic [6:0] wgt_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [9:0] NP = 10'(IMG_DIM * IMG_DIM);
  localparam logic [6:0] NW = 7'(K_DIM * K_DIM * W_BITS);
  localparam logic [6:0] WMAX = 7'(W_BITS - 1);
  logic [1:0] state;
  logic [IMG_DIM*IMG_DIM-1:0] pix_q;
  logic [K_DIM*K_DIM*W_BITS-1:0] wgt_q;
  logic [6:0] w_base, w_bit;
  logic acc, take_p, take_w;
  logic [9:0] pix_n;
  logic [6:0] wgt_n;
  always_comb begin
    acc = en_wr && bit_valid && state != DONE;
    take_p = acc && pix_count < NP;
    take_w = acc && wgt_count < NW;
    pix_n = pix_count + 10'(take_p);
    wgt_n = wgt_count + 7'(take_w);
  end
  // Packed row-major layout makes the running count the flat pixel index; weight bits land MSB first within each word
  assign pixels = pix_q;
  assign weights = wgt_q;
  assign load_done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pix_q <= '0;
      wgt_q <= '0;
      pix_count <= '0;
      wgt_count <= '0;
      w_base <= '0;
      w_bit <= '0;
    end else if (!en_wr) begin
      state <= IDLE;
      pix_count <= '0;
      wgt_count <= '0;
      w_base <= '0;
      w_bit <= '0;
    end else begin
      state <= (pix_n == NP && wgt_n == NW) ? DONE : LOAD;
      pix_count <= pix_n;
      wgt_count <= wgt_n;
      if (take_p) pix_q[pix_count] <= d_in_p;
      if (take_w) begin
        wgt_q[w_base + WMAX - w_bit] <= d_in_w;
        w_bit <= (w_bit == WMAX) ? '0 : w_bit + 7'd1;
        w_base <= (w_bit == WMAX) ? w_base + 7'(W_BITS) : w_base;
      end
    end
  end
endmodule

// File: tb/tb_bnn_serial_loader.sv
// tb_bnn_serial_loader: directed loads checked every cycle against an array-level model, plus literal spot checks
module tb_bnn_serial_loader;
  localparam int D = 28, K = 3, WB = 8, NP = 784, NW = 72, BW = 784;
  logic clk = 0, reset = 1, en_wr = 0, bit_valid = 0, d_in_p = 0, d_in_w = 0;
  logic [D-1:0][D-1:0] pixels;
  logic [K-1:0][K-1:0][WB-1:0] weights;
  logic load_done;
  logic [9:0] pix_count;
  logic [6:0] wgt_count;
  int checks = 0, errors = 0;
  bit cmp_on = 0;
  logic [D-1:0][D-1:0] m_pix, pat;
  logic [K-1:0][K-1:0][WB-1:0] m_w, wpat;
  int m_pc, m_wc;
  bit m_done;
  int first_done, wc72;

  always #5 clk = ~clk;

  bnn_serial_loader dut (
    .clk(clk), .reset(reset), .en_wr(en_wr), .bit_valid(bit_valid),
    .d_in_p(d_in_p), .d_in_w(d_in_w), .pixels(pixels), .weights(weights),
    .load_done(load_done), .pix_count(pix_count), .wgt_count(wgt_count)
  );

  always @(posedge clk) begin
    if (reset) begin
      m_pix = '0; m_w = '0; m_pc = 0; m_wc = 0; m_done = 0;
    end else if (!en_wr) begin
      m_pc = 0; m_wc = 0; m_done = 0;
    end else begin
      if (bit_valid && !m_done) begin
        if (m_pc < NP) begin m_pix[m_pc / D][m_pc % D] = d_in_p; m_pc++; end
        if (m_wc < NW) begin m_w[(m_wc / WB) / K][(m_wc / WB) % K][WB - 1 - m_wc % WB] = d_in_w; m_wc++; end
      end
      m_done = (m_pc == NP && m_wc == NW);
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      checks += 3;
      if (pixels !== m_pix) begin errors++; $display("FAIL cmp_pixels t=%0t got %0h exp %0h", $time, pixels, m_pix); end
      if (weights !== m_w) begin errors++; $display("FAIL cmp_weights t=%0t got %0h exp %0h", $time, weights, m_w); end
      if ({load_done, pix_count, wgt_count} !== {m_done, 10'(m_pc), 7'(m_wc)})
        begin errors++; $display("FAIL cmp_ctl t=%0t got done=%b pc=%0d wc=%0d exp done=%b pc=%0d wc=%0d",
          $time, load_done, pix_count, wgt_count, m_done, m_pc, m_wc); end
    end
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %0h exp %0h", name, act, exp); end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drop();
    @(negedge clk); en_wr = 0; bit_valid = 0; step();
  endtask

  function automatic logic pbit(input int i);
    return 1'(((i / D) + (i % D)) & 1);
  endfunction

  function automatic logic wbit(input int i);
    logic [7:0] w;
    w = 8'((i / WB) * 17);
    return w[WB - 1 - i % WB];
  endfunction

  task automatic run_load(input bit gapped, input bit ones, input int max_valid, output int edges);
    int v;
    v = 0; edges = 0; first_done = -1; wc72 = -1;
    while (v < max_valid && edges < 4000) begin
      @(negedge clk);
      en_wr = 1;
      bit_valid = gapped ? (edges % 2 == 0) : 1'b1;
      d_in_p = ones ? 1'b1 : pbit(v);
      d_in_w = (v < NW) ? wbit(v) : 1'b1;
      step();
      edges++;
      if (bit_valid) v++;
      if (load_done && first_done < 0) first_done = edges;
      if (wgt_count == 7'd72 && wc72 < 0) wc72 = edges;
    end
    chk("load_bound", BW'(v), BW'(max_valid));
  endtask

  initial begin
    int e;
    for (int r = 0; r < D; r++) for (int c = 0; c < D; c++) pat[r][c] = 1'((r + c) & 1);
    for (int k = 0; k < K * K; k++) wpat[k / K][k % K] = 8'(k * 17);
    step();
    cmp_on = 1;
    @(negedge clk); reset = 0; step();
    chk("rst_pixels", BW'(pixels), '0);
    chk("rst_weights", BW'(weights), '0);
    chk("rst_done", BW'(load_done), '0);
    chk("rst_counts", BW'({pix_count, wgt_count}), '0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      en_wr = 0; bit_valid = 1'($urandom); d_in_p = 1'($urandom); d_in_w = 1'($urandom);
    end
    step();
    chk("idle_outputs", BW'({pixels, weights, load_done, pix_count, wgt_count}), '0);
    run_load(0, 0, NP, e);
    chk("full_done_edge", BW'(first_done), BW'(784));
    chk("full_wc72_edge", BW'(wc72), BW'(72));
    chk("w00", BW'(weights[0][0]), BW'(8'h00));
    chk("w11", BW'(weights[1][1]), BW'(8'h44));
    chk("w22", BW'(weights[2][2]), BW'(8'h88));
    chk("px_0_1", BW'(pixels[0][1]), BW'(1'b1));
    chk("px_1_0", BW'(pixels[1][0]), BW'(1'b1));
    chk("px_27_27", BW'(pixels[27][27]), BW'(1'b0));
    chk("full_pixels", BW'(pixels), BW'(pat));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); en_wr = 1; bit_valid = 1; d_in_p = 1; d_in_w = 1; step();
    end
    chk("hold_done", BW'(load_done), BW'(1'b1));
    chk("hold_pixels", BW'(pixels), BW'(pat));
    chk("hold_weights", BW'(weights), BW'(wpat));
    drop();
    chk("drop_ctl", BW'({load_done, pix_count, wgt_count}), '0);
    chk("drop_pixels", BW'(pixels), BW'(pat));
    chk("drop_weights", BW'(weights), BW'(wpat));
    @(negedge clk); reset = 1; step();
    @(negedge clk); reset = 0; step();
    chk("rst2_pixels", BW'(pixels), '0);
    run_load(1, 0, NP, e);
    chk("gap_done_edge", BW'(first_done), BW'(1567));
    chk("gap_pixels", BW'(pixels), BW'(pat));
    chk("gap_weights", BW'(weights), BW'(wpat));
    drop();
    run_load(0, 0, 100, e);
    drop();
    run_load(0, 1, 28, e);
    chk("abort_row0", BW'(pixels[0]), BW'(28'hfffffff));
    chk("abort_row1", BW'(pixels[1]), BW'(pat[1]));
    chk("abort_row4", BW'(pixels[4]), BW'(pat[4]));
    chk("abort_pc", BW'(pix_count), BW'(28));
    drop();
    run_load(0, 0, 500, e);
    @(negedge clk); reset = 1; en_wr = 1; bit_valid = 1; d_in_p = 1; d_in_w = 1; step();
    chk("midrst_arrays", BW'({pixels, weights}), '0);
    chk("midrst_ctl", BW'({load_done, pix_count, wgt_count}), '0);
    @(negedge clk); reset = 0; en_wr = 0; bit_valid = 0; step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
